// File: rtl/magnitude_pkg.sv
// Shared FSM type and datapath constants for the magnitude scheduler slice.
package magnitude_pkg;

  localparam int unsigned MAGNITUDE_LATENCY = 5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;

endpackage

// File: rtl/magnitude.sv
// Fixed-latency |I,Q| pipeline: 2 stages of square/sum, 3 stages of floor square root.
// No reset on the datapath; the valid pipe powers up with whatever it holds.
module magnitude
  import magnitude_pkg::*;
#(
  parameter int unsigned INPUT_BITS  = 16,
  parameter int unsigned OUTPUT_BITS = INPUT_BITS + 1
) (
  input  logic                   clk,
  input  logic                   input_ready,
  input  logic [INPUT_BITS-1:0]  input_1,
  input  logic [INPUT_BITS-1:0]  input_2,
  output logic                   output_ready,
  output logic [OUTPUT_BITS-1:0] output_1
);

  localparam int unsigned SqBits = 2 * INPUT_BITS;
  localparam int unsigned RootBits = 2 * OUTPUT_BITS + 1;
  localparam int Per = (int'(OUTPUT_BITS) + 2) / 3;
  localparam int Top = int'(OUTPUT_BITS) - 1;

  typedef struct packed {
    logic [RootBits-1:0] op;
    logic [RootBits-1:0] res;
  } root_t;

  // Digit-by-digit floor sqrt, result bits hi down to lo.
  function automatic root_t root_iters(root_t s, int hi, int lo);
    root_t r;
    logic [RootBits-1:0] one;
    logic [RootBits-1:0] trial;
    r = s;
    for (int k = Top; k >= 0; k--) begin
      if (k <= hi && k >= lo) begin
        one   = RootBits'(1) << (2 * k);
        trial = r.res + one;
        if (r.op >= trial) begin
          r.op  = r.op - trial;
          r.res = (r.res >> 1) + one;
        end else begin
          r.res = r.res >> 1;
        end
      end
    end
    return r;
  endfunction

  logic signed [SqBits-1:0] ext_1, ext_2;
  logic [MAGNITUDE_LATENCY-1:0] valid_q;
  logic [SqBits-1:0] sq_1_q, sq_2_q;
  logic [RootBits-1:0] sum_q;
  root_t root_1_q, root_2_q, root_3_q;

  assign ext_1 = {{INPUT_BITS{input_1[INPUT_BITS-1]}}, input_1};
  assign ext_2 = {{INPUT_BITS{input_2[INPUT_BITS-1]}}, input_2};

  always_ff @(posedge clk) begin
    valid_q  <= {valid_q[MAGNITUDE_LATENCY-2:0], input_ready};
    sq_1_q   <= ext_1 * ext_1;
    sq_2_q   <= ext_2 * ext_2;
    sum_q    <= RootBits'(sq_1_q) + RootBits'(sq_2_q);
    root_1_q <= root_iters(root_t'{op: sum_q, res: '0}, Top, Top - Per + 1);
    root_2_q <= root_iters(root_1_q, Top - Per, Top - 2 * Per + 1);
    root_3_q <= root_iters(root_2_q, Top - 2 * Per, 0);
  end

  assign output_ready = valid_q[MAGNITUDE_LATENCY-1];
  assign output_1     = OUTPUT_BITS'(root_3_q.res);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr, wrapping, as one-hot grant + index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IDX_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [IDX_BITS-1:0] winner,
  output logic                found
);

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      automatic int unsigned idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[IDX_BITS'(idx)]) begin
        found              = 1'b1;
        winner             = IDX_BITS'(idx);
        grant[IDX_BITS'(idx)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/magnitude_scheduler.sv
// Round-robin sharing of one magnitude pipeline between channels, with tag-routed results,
// enable/drain control and a sticky tag/result misalignment flag.
module magnitude_scheduler
  import magnitude_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned INPUT_BITS   = 16,
  parameter int unsigned OUTPUT_BITS  = INPUT_BITS + 1,
  parameter int unsigned PIPE_LATENCY = MAGNITUDE_LATENCY,
  parameter int unsigned CHANNEL_BITS = $clog2(NUM_CHANNELS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [NUM_CHANNELS-1:0]              req_valid,
  input  logic [NUM_CHANNELS*INPUT_BITS-1:0]   req_input_1,
  input  logic [NUM_CHANNELS*INPUT_BITS-1:0]   req_input_2,
  output logic [NUM_CHANNELS-1:0]              req_ready,
  output logic                                 result_valid,
  output logic [CHANNEL_BITS-1:0]              result_channel,
  output logic [OUTPUT_BITS-1:0]               result_1,
  output logic                                 busy,
  output logic                                 drain_done,
  output logic                                 error
);

  // Back-to-back issue can hold PIPE_LATENCY+2 pairs before the first decrement lands.
  localparam int unsigned InflightBits = $clog2(PIPE_LATENCY + 3);
  localparam int unsigned WarmupBits   = $clog2(PIPE_LATENCY + 2);
  localparam logic [WarmupBits-1:0] WarmupDone = WarmupBits'(PIPE_LATENCY + 1);
  localparam logic [CHANNEL_BITS-1:0] LastChannel = CHANNEL_BITS'(NUM_CHANNELS - 1);

  sched_state_t state_q, state_d;
  logic grant_en, transfer;
  logic [NUM_CHANNELS-1:0] arb_grant;
  logic [CHANNEL_BITS-1:0] arb_winner, rr_ptr_q;
  logic arb_found;

  logic issue_valid_q;
  logic [CHANNEL_BITS-1:0] issue_ch_q;
  logic [INPUT_BITS-1:0] issue_1_q, issue_2_q;
  logic [PIPE_LATENCY-1:0] tag_valid_q;
  logic [PIPE_LATENCY-1:0][CHANNEL_BITS-1:0] tag_ch_q;
  logic mag_output_ready, tag_out_valid;
  logic [OUTPUT_BITS-1:0] mag_result;

  logic result_valid_q, error_q;
  logic [CHANNEL_BITS-1:0] result_channel_q;
  logic [OUTPUT_BITS-1:0] result_q;
  logic [InflightBits-1:0] inflight_q;
  logic [WarmupBits-1:0] warmup_q;

  rr_arbiter #(
    .NUM_REQ  (NUM_CHANNELS),
    .IDX_BITS (CHANNEL_BITS)
  ) u_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .grant  (arb_grant),
    .winner (arb_winner),
    .found  (arb_found)
  );

  magnitude #(
    .INPUT_BITS  (INPUT_BITS),
    .OUTPUT_BITS (OUTPUT_BITS)
  ) u_magnitude (
    .clk          (clk),
    .input_ready  (issue_valid_q),
    .input_1      (issue_1_q),
    .input_2      (issue_2_q),
    .output_ready (mag_output_ready),
    .output_1     (mag_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                  state_d = RUN;
        else if (inflight_q == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_en   = 1'b0;
    drain_done = 1'b0;
    unique case (state_q)
      RUN:     grant_en = enable;
      DRAIN:   drain_done = !enable && (inflight_q == '0);
      default: ;
    endcase
  end

  assign req_ready     = grant_en ? arb_grant : '0;
  assign transfer      = grant_en && arb_found;
  assign tag_out_valid = tag_valid_q[PIPE_LATENCY-1];
  assign busy          = (state_q != IDLE) || (inflight_q != '0);

  always_ff @(posedge clk) begin
    if (transfer) begin
      issue_1_q <= req_input_1[32'(arb_winner) * INPUT_BITS +: INPUT_BITS];
      issue_2_q <= req_input_2[32'(arb_winner) * INPUT_BITS +: INPUT_BITS];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q         <= '0;
      issue_valid_q    <= 1'b0;
      issue_ch_q       <= '0;
      tag_valid_q      <= '0;
      tag_ch_q         <= '0;
      result_valid_q   <= 1'b0;
      result_channel_q <= '0;
      result_q         <= '0;
      inflight_q       <= '0;
      warmup_q         <= '0;
      error_q          <= 1'b0;
    end else begin
      if (transfer) begin
        rr_ptr_q   <= (arb_winner == LastChannel) ? '0 : arb_winner + CHANNEL_BITS'(1);
        issue_ch_q <= arb_winner;
      end
      issue_valid_q <= transfer;
      tag_valid_q   <= {tag_valid_q[PIPE_LATENCY-2:0], issue_valid_q};
      tag_ch_q      <= {tag_ch_q[PIPE_LATENCY-2:0], issue_ch_q};

      result_valid_q <= mag_output_ready && tag_out_valid;
      if (mag_output_ready && tag_out_valid) begin
        result_channel_q <= tag_ch_q[PIPE_LATENCY-1];
        result_q         <= mag_result;
      end

      unique case ({transfer, result_valid_q})
        2'b10:   inflight_q <= inflight_q + InflightBits'(1);
        2'b01:   inflight_q <= inflight_q - InflightBits'(1);
        default: ;
      endcase

      // Until the unreset datapath has flushed, its valid stream is not trustworthy.
      if (warmup_q != WarmupDone) warmup_q <= warmup_q + WarmupBits'(1);
      else if (mag_output_ready != tag_out_valid) error_q <= 1'b1;
    end
  end

  assign result_valid   = result_valid_q;
  assign result_channel = result_channel_q;
  assign result_1       = result_q;
  assign error          = error_q;

endmodule
